// File: rtl/rr_burst_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_burst_mux_arbiter_if
// Brief    : Bundle of the four requester valid/ready/last/data channels and
//            the single registered output channel of the burst arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface rr_burst_mux_arbiter_if #(
  parameter int DATA_WIDTH = 4
);
  logic [3:0]              in_valid;
  logic [3:0]              in_last;
  logic [4*DATA_WIDTH-1:0] in_data;
  logic [3:0]              in_ready;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_last;
  logic [1:0]              out_src;
  logic                    out_ready;

  // Arbiter side: consumes requester beats, produces the merged stream.
  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_src
  );

  // Environment side: requesters plus downstream consumer.
  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_src
  );
endinterface
`default_nettype wire

// File: rtl/rr_burst_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_burst_mux_arbiter
// Brief    : Round-robin arbiter sharing one registered output channel between
//            four valid/ready requesters; the grant is locked for a whole
//            burst (first beat through the beat carrying in_last).
// Revision : 1.0  initial release
// ============================================================================
module rr_burst_mux_arbiter #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_burst_mux_arbiter_if.slave bus
);

  localparam int c_NUM_REQ = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_ptr;
  logic [1:0]            w_ptr_nxt;
  logic [1:0]            r_owner;
  logic [1:0]            w_owner_nxt;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic [1:0]            r_out_src;

  logic                  w_load_ok;
  logic [1:0]            w_idle_grant;
  logic                  w_idle_any;
  logic [1:0]            w_grant;
  logic                  w_grant_act;
  logic [3:0]            w_ready;
  logic                  w_accept;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // The single output stage can take a new beat when empty or draining.
  assign w_load_ok = !r_out_valid || bus.out_ready;

  // Rotating priority search: first valid requester starting at r_ptr.
  // Walking backwards lets the lowest offset overwrite the others.
  always_comb begin
    w_idle_grant = r_ptr;
    w_idle_any   = 1'b0;
    for (int k = c_NUM_REQ - 1; k >= 0; k--) begin
      if (bus.in_valid[r_ptr + 2'(k)]) begin
        w_idle_grant = r_ptr + 2'(k);
        w_idle_any   = 1'b1;
      end
    end
  end

  // Data path: plain 4:1 mux steered by the current grant.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < c_NUM_REQ; i++) begin
      if (w_grant == 2'(i)) begin
        w_sel_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitration FSM: grant selection, ready generation and next state.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_grant     = r_ptr;
    w_grant_act = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_grant     = w_idle_grant;
        w_grant_act = w_idle_any;
      end
      ST_BURST: begin
        // Owner keeps the channel even through idle gaps.
        w_grant     = r_owner;
        w_grant_act = 1'b1;
      end
      default: begin
        w_grant     = r_ptr;
        w_grant_act = 1'b0;
      end
    endcase

    // in_ready is forced low while reset is asserted, independent of inputs.
    w_ready = '0;
    if (rst_n && w_grant_act && w_load_ok) begin
      w_ready = 4'b0001 << w_grant;
    end

    w_accept   = bus.in_valid[w_grant] && w_ready[w_grant];
    w_sel_last = bus.in_last[w_grant];

    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_last) begin
            w_ptr_nxt = w_grant + 2'd1;
          end else begin
            w_state_nxt = ST_BURST;
            w_owner_nxt = w_grant;
          end
        end
        ST_BURST: begin
          if (w_sel_last) begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = r_owner + 2'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Arbitration state register; pointer only moves on burst completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Output stage: load accepted beat, otherwise drain on downstream accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= 2'd0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_src   <= w_grant;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_rr_burst_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_burst_mux_arbiter
// Brief    : Directed self-checking bench for the round-robin burst arbiter.
//            Inputs change 2 time units after the rising edge; in_ready is
//            sampled 1 unit later, registered outputs right after the edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_burst_mux_arbiter;

  localparam int DATA_WIDTH = 4;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  rr_burst_mux_arbiter_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  rr_burst_mux_arbiter #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all requester inputs at once.
  task automatic set_in(input logic [3:0] v, input logic [3:0] l, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_data  = d;
  endtask

  // Advance to 2 units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Synchronous-looking reset sequence leaving the bench at edge+2.
  task automatic do_reset();
    rst_n = 1'b0;
    set_in(4'b0000, 4'b0000, 16'h0000);
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    set_in(4'b1111, 4'b1111, 16'h4321);
    tick();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 4'b0000) $display("FAIL rst_in_ready got %b want 0000", bus.in_ready); else n_pass++;
    n_total++; if ({bus.out_data, bus.out_last, bus.out_src} !== 7'd0) $display("FAIL rst_out_regs got %h/%b/%0d want 0/0/0", bus.out_data, bus.out_last, bus.out_src); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (bus.in_ready !== 4'b0001) $display("FAIL rst_release_grant got %b want 0001", bus.in_ready); else n_pass++;
    tick();
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0) $display("FAIL rst_first_beat got v=%b src=%0d want v=1 src=0", bus.out_valid, bus.out_src); else n_pass++;
    // ptr has moved to 1; an asynchronous reset mid-cycle must clear it all.
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_async_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 4'b0000) $display("FAIL rst_async_in_ready got %b want 0000", bus.in_ready); else n_pass++;
    #1 rst_n = 1'b1;
    #1;
    n_total++; if (bus.in_ready !== 4'b0001) $display("FAIL rst_ptr_zero got %b want 0001", bus.in_ready); else n_pass++;
    set_in(4'b0000, 4'b0000, 16'h0000);
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    set_in(4'b1111, 4'b1111, 16'h4321);
    for (int k = 0; k < 5; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      n_total++; if (bus.in_ready !== exp_rdy) $display("FAIL rr_ready[%0d] got %b want %b", k, bus.in_ready, exp_rdy); else n_pass++;
      @(posedge clk); #2;
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'(k % 4)) $display("FAIL rr_src[%0d] got v=%b src=%0d want v=1 src=%0d", k, bus.out_valid, bus.out_src, k % 4); else n_pass++;
      n_total++; if (bus.out_data !== 4'((k % 4) + 1) || bus.out_last !== 1'b1) $display("FAIL rr_data[%0d] got %h/%b want %h/1", k, bus.out_data, bus.out_last, (k % 4) + 1); else n_pass++;
    end
    set_in(4'b0000, 4'b0000, 16'h0000);
    tick();
  endtask

  task automatic test_burst_lock();
    logic [3:0] beat_data [3];
    beat_data[0] = 4'h7; beat_data[1] = 4'h8; beat_data[2] = 4'h9;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      set_in(4'b0110, (b == 2) ? 4'b0110 : 4'b0100, {4'h0, 4'hE, beat_data[b], 4'h0});
      #1;
      n_total++; if (bus.in_ready !== 4'b0010) $display("FAIL burst_ready[%0d] got %b want 0010", b, bus.in_ready); else n_pass++;
      @(posedge clk); #2;
      n_total++; if (bus.out_src !== 2'd1 || bus.out_data !== beat_data[b] || bus.out_last !== (b == 2)) $display("FAIL burst_beat[%0d] got src=%0d d=%h l=%b want src=1 d=%h l=%b", b, bus.out_src, bus.out_data, bus.out_last, beat_data[b], b == 2);
      else n_pass++;
      if (b == 1) begin
        // Idle gap from the owner: port2 still must not be granted.
        set_in(4'b0100, 4'b0100, 16'h0E00);
        #1;
        n_total++; if (bus.in_ready !== 4'b0010) $display("FAIL burst_gap_ready got %b want 0010", bus.in_ready); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL burst_gap_valid got %b want 0", bus.out_valid); else n_pass++;
      end
    end
    set_in(4'b0100, 4'b0100, 16'h0E00);
    #1;
    n_total++; if (bus.in_ready !== 4'b0100) $display("FAIL burst_next_ready got %b want 0100", bus.in_ready); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (bus.out_src !== 2'd2 || bus.out_data !== 4'hE) $display("FAIL burst_next_beat got src=%0d d=%h want src=2 d=e", bus.out_src, bus.out_data); else n_pass++;
    set_in(4'b0000, 4'b0000, 16'h0000);
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_in(4'b0001, 4'b0001, 16'h000A);
    tick();
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA) $display("FAIL bp_load got v=%b d=%h want v=1 d=a", bus.out_valid, bus.out_data); else n_pass++;
    bus.out_ready = 1'b0;
    set_in(4'b0010, 4'b0010, 16'h0050);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++; if (bus.in_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b want 0000", c, bus.in_ready); else n_pass++;
      @(posedge clk); #2;
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA || bus.out_src !== 2'd0) $display("FAIL bp_hold[%0d] got v=%b d=%h src=%0d want v=1 d=a src=0", c, bus.out_valid, bus.out_data, bus.out_src);
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    #1;
    n_total++; if (bus.in_ready !== 4'b0010) $display("FAIL bp_release_ready got %b want 0010", bus.in_ready); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h5 || bus.out_src !== 2'd1) $display("FAIL bp_next_beat got v=%b d=%h src=%0d want v=1 d=5 src=1", bus.out_valid, bus.out_data, bus.out_src);
    else n_pass++;
    set_in(4'b0000, 4'b0000, 16'h0000);
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(4'b0100, 4'b0100, 16'h0300);
    #1;
    n_total++; if (bus.in_ready !== 4'b0100) $display("FAIL wrap_p2_ready got %b want 0100", bus.in_ready); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (bus.out_src !== 2'd2 || bus.out_data !== 4'h3) $display("FAIL wrap_p2_beat got src=%0d d=%h want src=2 d=3", bus.out_src, bus.out_data); else n_pass++;
    set_in(4'b1001, 4'b1001, 16'hC00B);
    #1;
    n_total++; if (bus.in_ready !== 4'b1000) $display("FAIL wrap_p3_ready got %b want 1000", bus.in_ready); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (bus.out_src !== 2'd3 || bus.out_data !== 4'hC) $display("FAIL wrap_p3_beat got src=%0d d=%h want src=3 d=c", bus.out_src, bus.out_data); else n_pass++;
    #1;
    n_total++; if (bus.in_ready !== 4'b0001) $display("FAIL wrap_p0_ready got %b want 0001", bus.in_ready); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (bus.out_src !== 2'd0 || bus.out_data !== 4'hB) $display("FAIL wrap_p0_beat got src=%0d d=%h want src=0 d=b", bus.out_src, bus.out_data); else n_pass++;
    set_in(4'b0000, 4'b0000, 16'h0000);
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_in(4'b0001, 4'b0000, 16'h0006);
    tick();
    n_total++; if (bus.out_src !== 2'd0 || bus.out_last !== 1'b0 || bus.out_valid !== 1'b1) $display("FAIL mrst_first got v=%b src=%0d l=%b want v=1 src=0 l=0", bus.out_valid, bus.out_src, bus.out_last);
    else n_pass++;
    set_in(4'b0110, 4'b0110, 16'h0210);
    #1;
    n_total++; if (bus.in_ready !== 4'b0001) $display("FAIL mrst_locked got %b want 0001", bus.in_ready); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) $display("FAIL mrst_async got v=%b rdy=%b want v=0 rdy=0000", bus.out_valid, bus.in_ready); else n_pass++;
    #1 rst_n = 1'b1;
    #1;
    n_total++; if (bus.in_ready !== 4'b0010) $display("FAIL mrst_after_ready got %b want 0010", bus.in_ready); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd1 || bus.out_data !== 4'h1) $display("FAIL mrst_after_beat got v=%b src=%0d d=%h want v=1 src=1 d=1", bus.out_valid, bus.out_src, bus.out_data);
    else n_pass++;
    set_in(4'b0000, 4'b0000, 16'h0000);
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.out_ready = 1'b1;
    set_in(4'b0000, 4'b0000, 16'h0000);
    #2;
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
